// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor computing A - B, LSB first,
// one full-subtractor step per clock. Start/busy/done handshake; the result and its
// borrow / signed-overflow / zero flags are held until the next operation completes.
//
// Ports:
//   iClk       rising-edge clock
//   iRstN      asynchronous active-low reset
//   iStart     request, sampled only while idle
//   iA, iB     minuend / subtrahend, captured on the accepting edge
//   oBusy      high whenever the FSM is not idle
//   oDone      one-cycle pulse; result outputs are valid from this cycle on
//   oDiff      A - B modulo 2^WIDTH
//   oBorrow    final borrow-out (A < B unsigned)
//   oOverflow  signed overflow of A - B
//   oZero      oDiff == 0
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oDiff,
  output logic             oBorrow,
  output logic             oOverflow,
  output logic             oZero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  logic             a_bit, b_bit, d_bit, bout;
  logic             last_bit;
  logic [WIDTH-1:0] res_full;

  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    d_bit    = a_bit ^ b_bit ^ borrow_q;
    bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    last_bit = (state_q == StRun) && (cnt_q == LastBit);
    // Difference bits enter from the MSB side, so after WIDTH steps bit 0 sits at bit 0.
    res_full = {d_bit, res_q[WIDTH-1:1]};
  end

  // FSM: state register
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iStart) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    oBusy = (state_q != StIdle);
    oDone = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          a_d      = iA;
          b_d      = iB;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      StRun: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = res_full;
        borrow_d = bout;
        if (last_bit) begin
          cnt_d  = '0;
          diff_d = res_full;
          bout_d = bout;
          // On the last step a_bit/b_bit are the operand sign bits and d_bit the result sign.
          ovf_d  = (a_bit != b_bit) && (d_bit != a_bit);
          zero_d = (res_full == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  ;
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign oDiff     = diff_q;
  assign oBorrow   = bout_q;
  assign oOverflow = ovf_q;
  assign oZero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed cases plus randomized ops checked
// against an arithmetic model of A - B.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         iClk;
  logic         iRstN;
  logic         iStart;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oDiff;
  logic         oBorrow;
  logic         oOverflow;
  logic         oZero;

  int total = 0;
  int bad   = 0;

  // Expected held result, packed as {diff, borrow, ovf, zero}.
  logic [10:0] held_exp;

  serial_subtractor #(.WIDTH(W)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iStart    (iStart),
    .iA        (iA),
    .iB        (iB),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oDiff     (oDiff),
    .oBorrow   (oBorrow),
    .oOverflow (oOverflow),
    .oZero     (oZero)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
    int          ud;
    int          sd;
    logic [7:0]  d;
    ud = int'(a) - int'(b);
    sd = int'($signed(a)) - int'($signed(b));
    d  = ud[7:0];
    return {d, (ud < 0), (sd > 127 || sd < -128), (d == 8'h00)};
  endfunction

  function automatic logic [10:0] outs();
    return {oDiff, oBorrow, oOverflow, oZero};
  endfunction

  // Runs one op from the IDLE cycle. If inject is set, a bogus start with A=B=FF is
  // pulsed while the op is running and must be ignored.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit inject);
    int          n;
    bit          seen;
    logic [10:0] exp;
    exp = model(a, b);
    @(negedge iClk);
    iA = a;
    iB = b;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    iA = W'($urandom);
    iB = W'($urandom);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      if (oDone) begin
        seen = 1;
      end else begin
        check("busy_in_op", oBusy, 1);
        check("hold", outs(), held_exp);
        if (inject && n == 2) begin
          @(negedge iClk);
          iStart = 1'b1;
          iA = 8'hFF;
          iB = 8'hFF;
        end
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        n++;
      end
    end
    check("latency", n, W);
    check("diff", oDiff, exp[10:3]);
    check("borrow", oBorrow, exp[2]);
    check("ovf", oOverflow, exp[1]);
    check("zero", oZero, exp[0]);
    check("busy_done", oBusy, 1);
    held_exp = exp;
    @(posedge iClk);
    #1;
    check("done_width", oDone, 0);
    check("busy_idle", oBusy, 0);
    check("hold_after", outs(), held_exp);
  endtask

  initial begin
    iRstN  = 1'b0;
    iStart = 1'b0;
    iA     = '0;
    iB     = '0;
    held_exp = '0;
    #12;
    check("rst_outs", outs(), 11'h000);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    @(negedge iClk);
    iRstN = 1'b1;
    @(posedge iClk);
    #1;

    // T1..T4
    do_op(8'h5A, 8'h23, 0);
    check("t1_diff", oDiff, 8'h37);
    do_op(8'h00, 8'h01, 0);
    check("t2_diff", oDiff, 8'hFF);
    do_op(8'h80, 8'h01, 0);
    check("t3a_ovf", oOverflow, 1);
    do_op(8'h7F, 8'hFF, 0);
    check("t3b_diff", oDiff, 8'h80);
    do_op(8'h3C, 8'h3C, 0);
    check("t4_zero", oZero, 1);

    // T5a: start request during RUN is ignored
    do_op(8'h10, 8'h01, 1);
    check("t5a_diff", oDiff, 8'h0F);

    // T5b: reset during bit 3 of a new op
    @(negedge iClk);
    iA = 8'hC3;
    iB = 8'h15;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRstN = 1'b0;
    #1;
    check("t5b_outs", outs(), 11'h000);
    check("t5b_busy", oBusy, 0);
    check("t5b_done", oDone, 0);
    held_exp = '0;
    @(negedge iClk);
    iRstN = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge iClk);
      #1;
      check("t5b_nodone", {oDone, oBusy}, 2'b00);
    end
    do_op(8'hC3, 8'h15, 0);
    check("t5b_after", oDiff, 8'hAE);

    // T6: random back-to-back ops, occasional ignored start pulses mid-run
    for (int k = 0; k < 1000; k++) begin
      do_op(8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
